tc_irq_ctrl: RTL and testbench

//  Interrupt flag/arbitration controller for the 8-bit timer/counter block.
//  - Latches overflow and compare-match events from NUM_TIMERS timers (TOV, OCFA, OCFB each).
//  - Masks them with TIMSK and the global SREG I-bit.
//  - Presents one fixed-priority vector to the CPU core over a req/ack/done handshake.
//  - Sits between the timer datapath and the core's interrupt entry logic.

---
 rtl/tc_irq_pkg.sv | 21 ++
 rtl/tc_irq_prio_enc.sv | 27 ++
 rtl/tc_irq_ctrl.sv | 123 ++++++++++++
 tb/tb_tc_irq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_irq_pkg.sv
// Shared types and helpers for the timer/counter interrupt controller.
// Contents: FSM state type, per-timer source offsets, source index helper.
package tc_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } tc_irq_state_e;

  // Source offset inside one timer's group of three flags.
  localparam int unsigned SRC_TOV  = 0;
  localparam int unsigned SRC_OCFA = 1;
  localparam int unsigned SRC_OCFB = 2;

  // Flat source index of event k of timer t.
  function automatic int unsigned src_idx(input int unsigned t, input int unsigned k);
    return 3 * t + k;
  endfunction

endpackage

// File: rtl/tc_irq_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports:
//   req_i   - request vector, bit 0 has the highest priority
//   valid_o - at least one request bit set
//   idx_o   - index of the lowest set bit (0 when none set)
module tc_irq_prio_enc #(
  parameter int unsigned Width = 6,
  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/tc_irq_ctrl.sv
// Interrupt flag register and fixed-priority request FSM for the timer block.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   flag_set                   - 1-cycle event pulses, index 3*t+k (TOV, OCFA, OCFB)
//   timsk, sreg_ie             - per-source and global enables
//   flag_clr_we, flag_clr_data - software write-one-to-clear of the flags
//   flags                      - registered flag view
//   irq_req, irq_vec           - request and vector to the core
//   irq_ack, irq_done          - core accept / return-from-interrupt
//   busy                       - request outstanding or being serviced
module tc_irq_ctrl
  import tc_irq_pkg::*;
#(
  parameter int unsigned NUM_TIMERS = 2,
  parameter logic [7:0]  VEC_BASE   = 8'h0E,
  localparam int unsigned N         = 3 * NUM_TIMERS,
  localparam int unsigned IdxW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] flag_set,
  input  logic [N-1:0] timsk,
  input  logic         sreg_ie,
  input  logic         flag_clr_we,
  input  logic [N-1:0] flag_clr_data,
  output logic [N-1:0] flags,
  output logic         irq_req,
  output logic [7:0]   irq_vec,
  input  logic         irq_ack,
  input  logic         irq_done,
  output logic         busy
);

  tc_irq_state_e   state_q, state_d;
  logic [N-1:0]    flags_q, flags_d;
  logic            irq_req_q, irq_req_d;
  logic [7:0]      irq_vec_q, irq_vec_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [N-1:0]    pend, swclr, ackclr;
  logic            win_valid;
  logic [IdxW-1:0] win_idx;

  assign pend = flags_q & timsk;

  tc_irq_prio_enc #(
    .Width(N)
  ) u_prio_enc (
    .req_i  (pend),
    .valid_o(win_valid),
    .idx_o  (win_idx)
  );

  // Flag register: a hardware set in the same cycle as any clear wins.
  always_comb begin
    swclr  = flag_clr_we ? flag_clr_data : '0;
    ackclr = '0;
    if (state_q == REQ && irq_ack) begin
      ackclr[idx_q] = 1'b1;
    end
    flags_d = flag_set | (flags_q & ~swclr & ~ackclr);
  end

  always_comb begin
    state_d   = state_q;
    irq_req_d = irq_req_q;
    irq_vec_d = irq_vec_q;
    idx_d     = idx_q;
    case (state_q)
      IDLE: begin
        if (sreg_ie && win_valid) begin
          state_d   = REQ;
          idx_d     = win_idx;
          irq_vec_d = VEC_BASE + 8'(win_idx);
          irq_req_d = 1'b1;
        end
      end
      REQ: begin
        // The latched source is not re-arbitrated; ack beats withdrawal.
        if (irq_ack) begin
          state_d   = SERVICE;
          irq_req_d = 1'b0;
        end else if (!pend[idx_q] || !sreg_ie) begin
          state_d   = IDLE;
          irq_req_d = 1'b0;
          irq_vec_d = '0;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        irq_req_d = 1'b0;
        irq_vec_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      flags_q   <= '0;
      irq_req_q <= 1'b0;
      irq_vec_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      irq_req_q <= irq_req_d;
      irq_vec_q <= irq_vec_d;
      idx_q     <= idx_d;
    end
  end

  assign flags   = flags_q;
  assign irq_req = irq_req_q;
  assign irq_vec = irq_vec_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_tc_irq_ctrl.sv
// Self-checking bench for tc_irq_ctrl: behavioural model compared every cycle
// plus directed scenarios with hand-computed expectations.
module tb_tc_irq_ctrl;
  import tc_irq_pkg::*;

  localparam int N = 6;
  localparam logic [7:0] VBASE = 8'h0E;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] flag_set, timsk, flag_clr_data;
  logic         sreg_ie, flag_clr_we, irq_ack, irq_done;
  logic [N-1:0] flags;
  logic         irq_req, busy;
  logic [7:0]   irq_vec;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  tc_irq_ctrl #(
    .NUM_TIMERS(2),
    .VEC_BASE  (8'h0E)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flag_set     (flag_set),
    .timsk        (timsk),
    .sreg_ie      (sreg_ie),
    .flag_clr_we  (flag_clr_we),
    .flag_clr_data(flag_clr_data),
    .flags        (flags),
    .irq_req      (irq_req),
    .irq_vec      (irq_vec),
    .irq_ack      (irq_ack),
    .irq_done     (irq_done),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Model: a waiting request, a serving phase, or nothing; source kept as an int.
  logic [N-1:0] m_flags;
  bit           m_busy, m_req;
  int           m_src;
  logic [7:0]   m_vec;

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] nf;
    logic [N-1:0] p;
    int           win;
    if (!rst_n) begin
      m_flags <= '0;
      m_busy  <= 1'b0;
      m_req   <= 1'b0;
      m_src   <= -1;
      m_vec   <= 8'h00;
    end else begin
      p = m_flags & timsk;
      for (int i = 0; i < N; i++) begin
        if (flag_set[i])                       nf[i] = 1'b1;
        else if (flag_clr_we && flag_clr_data[i]) nf[i] = 1'b0;
        else if (m_req && irq_ack && i == m_src)  nf[i] = 1'b0;
        else                                   nf[i] = m_flags[i];
      end
      m_flags <= nf;
      if (!m_busy) begin
        win = -1;
        for (int i = N - 1; i >= 0; i--) if (p[i]) win = i;
        if (sreg_ie && win >= 0) begin
          m_busy <= 1'b1;
          m_req  <= 1'b1;
          m_src  <= win;
          m_vec  <= VBASE + 8'(win);
        end
      end else if (m_req) begin
        if (irq_ack) begin
          m_req <= 1'b0;
        end else if (!p[m_src] || !sreg_ie) begin
          m_busy <= 1'b0;
          m_req  <= 1'b0;
          m_vec  <= 8'h00;
        end
      end else if (irq_done) begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_flags", 32'(flags), 32'(m_flags));
      check("cyc_irq_req", 32'(irq_req), 32'(m_req));
      check("cyc_irq_vec", 32'(irq_vec), 32'(m_vec));
      check("cyc_busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flag_set = '0; timsk = '0; flag_clr_data = '0;
    sreg_ie = 1'b0; flag_clr_we = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    #12;
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_irq_req", 32'(irq_req), 32'h0);
    check("rst_irq_vec", 32'(irq_vec), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    started = 1'b1;
    tick();

    // Single source OCFA0 (index 1)
    timsk = 6'h02; sreg_ie = 1'b1;
    flag_set[src_idx(0, SRC_OCFA)] = 1'b1;
    tick();
    flag_set = '0;
    check("single_flags", 32'(flags), 32'h02);
    check("single_req_early", 32'(irq_req), 32'h0);
    tick();
    check("single_req", 32'(irq_req), 32'h1);
    check("single_vec", 32'(irq_vec), 32'h0F);
    check("single_model_vec", 32'(m_vec), 32'h0F);
    tick();
    tick();
    check("single_vec_hold", 32'(irq_vec), 32'h0F);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("single_ack_flags", 32'(flags), 32'h0);
    check("single_ack_req", 32'(irq_req), 32'h0);
    check("single_service_busy", 32'(busy), 32'h1);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check("single_done_busy", 32'(busy), 32'h0);

    // Priority: sources 2 and 5 together
    timsk = 6'h3F;
    flag_set = 6'h24;
    tick();
    flag_set = '0;
    tick();
    check("prio_vec1", 32'(irq_vec), 32'h10);
    check("prio_model_vec1", 32'(m_vec), 32'h10);
    irq_ack = 1'b1; irq_done = 1'b1;  // done alongside ack in REQ is ignored
    tick();
    irq_ack = 1'b0; irq_done = 1'b0;
    check("prio_flags_after_ack", 32'(flags), 32'h20);
    check("prio_busy_service", 32'(busy), 32'h1);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check("prio_idle", 32'(busy), 32'h0);
    tick();
    check("prio_req2", 32'(irq_req), 32'h1);
    check("prio_vec2", 32'(irq_vec), 32'h13);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check("prio_flags_empty", 32'(flags), 32'h0);

    // Withdraw by software clear while in REQ
    timsk = 6'h02;
    flag_set = 6'h02;
    tick();
    flag_set = '0;
    tick();
    check("wd_req", 32'(irq_req), 32'h1);
    flag_clr_we = 1'b1; flag_clr_data = 6'h02;
    tick();
    flag_clr_we = 1'b0; flag_clr_data = '0;
    check("wd_flags", 32'(flags), 32'h0);
    tick();
    check("wd_req_drop", 32'(irq_req), 32'h0);
    check("wd_busy", 32'(busy), 32'h0);
    check("wd_vec", 32'(irq_vec), 32'h0);

    // Set beats clear
    timsk = 6'h00;
    flag_set = 6'h01;
    tick();
    flag_clr_we = 1'b1; flag_clr_data = 6'h01;
    tick();
    check("setwin_flags", 32'(flags), 32'h01);
    check("setwin_model", 32'(m_flags), 32'h01);
    flag_set = '0;
    tick();
    flag_clr_we = 1'b0; flag_clr_data = '0;
    check("clr_flags", 32'(flags), 32'h0);

    // Gating by sreg_ie, stray ack/done in IDLE ignored
    sreg_ie = 1'b0; timsk = 6'h01;
    flag_set = 6'h01;
    tick();
    flag_set = '0;
    tick();
    tick();
    check("gate_req", 32'(irq_req), 32'h0);
    check("gate_flags", 32'(flags), 32'h01);
    irq_done = 1'b1; irq_ack = 1'b1;
    tick();
    irq_done = 1'b0; irq_ack = 1'b0;
    check("gate_stray_flags", 32'(flags), 32'h01);
    check("gate_stray_busy", 32'(busy), 32'h0);
    sreg_ie = 1'b1;
    tick();
    check("gate_req_on", 32'(irq_req), 32'h1);
    check("gate_vec", 32'(irq_vec), 32'h0E);

    // Async reset in the middle of REQ
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 32'(irq_req), 32'h0);
    check("async_flags", 32'(flags), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sreg_ie = 1'b0;
    tick();
    check("post_rst_req", 32'(irq_req), 32'h0);
    tick();

    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
